bus_dest_sequencer: RTL and testbench
=====================================

# bus_dest_sequencer

- Write-side partner of the 32-bit datapath bus source multiplexer.
- Accepts queued register-transfer requests (source code, destination code) and drives the 5-bit source select `Scode` onto the bus mux.
- After one settle cycle, pulses exactly one one-hot destination load enable so the target register captures `BusMuxOut`.
- Sits between the control unit and the register file / special registers.

## Interface
- `DEPTH`, 2 — request FIFO entries (power of two, ≥2).
- `clock`  in  1 — single clock; all state rising-edge.
- `clear`  in  1 — asynchronous, active-low reset.
- `req_valid`  in  1 — request present.
- `req_ready`  out  1 — FIFO not full; transfer accepted when `req_valid && req_ready`.
- `req_src`  in  5 — source code, same map as the bus mux: 0–15 R0–R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C.
- `req_dst`  in  5 — destination code, same map.
- `Scode`  out  5 — bus mux select.
- `load_en`  out  24 — one-hot destination load, bit index = code.
- `busy`  out  1 — FSM not IDLE or FIFO non-empty.
- `done`  out  1 — one-cycle pulse, coincident with the `load_en` pulse.
- `err`  out  1 — one-cycle pulse when a request is dropped as illegal.

## Operation
- Legal sources: codes 0–23.
- Legal destinations: 0–17, 20, 21.
  - ZHI, ZLO, InPort and C are not bus-loadable.
  - Codes 24–31 are illegal everywhere.
- Legality is checked at FIFO pop, not at push; illegal requests occupy a FIFO slot.
- FSM states: IDLE, DRIVE, LOAD.
  - IDLE: FIFO non-empty → pop head.
    - Legal → latch src/dst, `Scode`←src, go to DRIVE.
    - Illegal → pulse `err`, stay in IDLE; the next pop happens the following cycle.
  - DRIVE: `Scode` held and bus settles; `load_en` = 0 → LOAD.
  - LOAD: `load_en[dst]`=1 and `done`=1 for this cycle only, `Scode` still held.
    - FIFO non-empty → pop and go directly to DRIVE (back-to-back); an illegal head pulses `err`, with `err` and `done` allowed in the same cycle, and goes to IDLE.
    - Otherwise → IDLE.
- `Scode` holds its last value in IDLE; it never changes during DRIVE or LOAD.
- `src == dst` is legal: a register reload of itself.
- Push and pop in the same cycle are allowed, including when full (`req_ready`=0 blocks the push regardless).
- FIFO: binary read/write pointers with one extra wrap bit.
  - full = pointers equal except MSB.
  - empty = pointers equal.

## Timing
- Reset (`clear`=0, asynchronous) values:
  - FSM IDLE; FIFO empty.
  - `Scode`=5'b0_0000, `load_en`=0, `done`=0, `err`=0, `busy`=0, `req_ready`=1.
- Latency from an accepted push at edge N (FSM IDLE, FIFO empty):
  - edge N+1: pop, enter DRIVE, `Scode` valid.
  - edge N+2: LOAD.
  - Destination captures at edge N+3.
- Throughput: one transfer per 2 cycles when back-to-back.
- `req_ready` is registered-state derived: it deasserts in the cycle after the FIFO becomes full.
- `clear` asserted mid-transfer aborts immediately.
  - `load_en` drops asynchronously; no partial load pulse survives.
  - Queued requests are discarded.

## Structure
- Package `bus_pkg`:
  - `typedef logic [4:0] bus_code_t`.
  - Named localparams for all 24 codes (`BUS_R0` … `BUS_C`).
  - Function `dst_legal(bus_code_t)`.
  - FSM state enum.
  - The mux should also import these codes.
- Sub-module `bus_req_fifo`:
  - Parameterised by `DEPTH`, width 10 (src,dst).
  - Ports: push/pop/full/empty/head.
- Top holds the FSM and the one-hot decode of dst to `load_en`.

## Test plan
- Single transfer: after reset, push (src=20 PC, dst=21 MDR) → `Scode`=20 one cycle later; next cycle `load_en`=24'h20_0000 and `done`=1; both 0 afterwards.
- Back-to-back: push (3→5), (16→7), (21→0) on consecutive cycles → `load_en` pulses 0x000020, 0x000080, 0x000001 on cycles 2, 4, 6 after the first push; `Scode` sequence 3, 16, 21.
- Illegal: push (2→18), then (4→22), then (25→1), then (1→2) → three `err` pulses, no `load_en`; then a normal transfer with `load_en`=0x000004.
- Full FIFO: DEPTH=2, hold `req_valid`=1 with 4 distinct requests → `req_ready` drops after 2 queue; all 4 complete in order; no request is lost or duplicated.
- Reset mid-LOAD: assert `clear` during LOAD with 2 queued requests → `load_en`=0 and `Scode`=0 immediately; after release `busy`=0 and no pulses occur.
- Self-transfer: push (9→9) → `Scode`=9, `load_en`=0x000200, `done`=1, `err`=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus code map, request record and sequencer state encoding for the
// datapath bus mux and the destination sequencer.
package bus_pkg;

  typedef logic [4:0] bus_code_t;

  localparam bus_code_t BUS_R0     = 5'd0;
  localparam bus_code_t BUS_R1     = 5'd1;
  localparam bus_code_t BUS_R2     = 5'd2;
  localparam bus_code_t BUS_R3     = 5'd3;
  localparam bus_code_t BUS_R4     = 5'd4;
  localparam bus_code_t BUS_R5     = 5'd5;
  localparam bus_code_t BUS_R6     = 5'd6;
  localparam bus_code_t BUS_R7     = 5'd7;
  localparam bus_code_t BUS_R8     = 5'd8;
  localparam bus_code_t BUS_R9     = 5'd9;
  localparam bus_code_t BUS_R10    = 5'd10;
  localparam bus_code_t BUS_R11    = 5'd11;
  localparam bus_code_t BUS_R12    = 5'd12;
  localparam bus_code_t BUS_R13    = 5'd13;
  localparam bus_code_t BUS_R14    = 5'd14;
  localparam bus_code_t BUS_R15    = 5'd15;
  localparam bus_code_t BUS_HI     = 5'd16;
  localparam bus_code_t BUS_LO     = 5'd17;
  localparam bus_code_t BUS_ZHI    = 5'd18;
  localparam bus_code_t BUS_ZLO    = 5'd19;
  localparam bus_code_t BUS_PC     = 5'd20;
  localparam bus_code_t BUS_MDR    = 5'd21;
  localparam bus_code_t BUS_INPORT = 5'd22;
  localparam bus_code_t BUS_C      = 5'd23;

  localparam int BUS_NUM_CODES = 24;
  localparam int BUS_REQ_W     = 10;

  typedef struct packed {
    bus_code_t src;
    bus_code_t dst;
  } bus_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2
  } seq_state_t;

  function automatic logic src_legal(input bus_code_t code);
    return (code <= BUS_C);
  endfunction

  // ZHI, ZLO, InPort and C are read-only from the bus side.
  function automatic logic dst_legal(input bus_code_t code);
    logic ok;
    ok = 1'b0;
    if (code <= BUS_LO) ok = 1'b1;
    else if ((code == BUS_PC) || (code == BUS_MDR)) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Small request FIFO: binary pointers carrying one wrap bit, so full/empty
// fall straight out of a pointer compare.
module bus_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_dest_sequencer.sv
// Drives the bus mux select for a queued transfer, waits one settle cycle,
// then pulses the one-hot destination load enable.
module bus_dest_sequencer
  import bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_src,
  input  logic [4:0]  req_dst,
  output logic [4:0]  Scode,
  output logic [23:0] load_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  seq_state_t r_state;
  seq_state_t w_state_next;
  bus_code_t  r_scode;
  bus_code_t  r_dst;
  bus_req_t   w_head;
  bus_req_t   w_wdata;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_err;
  logic       w_head_legal;

  assign w_wdata.src = req_src;
  assign w_wdata.dst = req_dst;

  bus_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BUS_REQ_W)
  ) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (req_valid),
    .wdata (w_wdata),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign w_head_legal = src_legal(w_head.src) && dst_legal(w_head.dst);

  // Illegal heads are popped and reported but never reach the bus.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_legal) w_state_next = ST_DRIVE;
          else              w_err        = 1'b1;
        end
      end
      ST_DRIVE: w_state_next = ST_LOAD;
      ST_LOAD: begin
        w_state_next = ST_IDLE;
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_legal) w_state_next = ST_DRIVE;
          else              w_err        = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
      r_scode <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop && w_head_legal) begin
        r_scode <= w_head.src;
        r_dst   <= w_head.dst;
      end
    end
  end

  // Decode straight from state so clear kills any load pulse at once.
  generate
    for (genvar gi = 0; gi < BUS_NUM_CODES; gi++) begin : g_load
      assign load_en[gi] = (r_state == ST_LOAD) && (r_dst == bus_code_t'(gi));
    end
  endgenerate

  assign Scode     = r_scode;
  assign done      = (r_state == ST_LOAD);
  assign err       = w_err;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign req_ready = !w_full;

endmodule

// File: tb/tb_bus_dest_sequencer.sv
// Scoreboard bench for bus_dest_sequencer: expected loads/errors are queued at
// push acceptance and retired by a negedge monitor.
module tb_bus_dest_sequencer;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic [4:0]  Scode;
  logic [23:0] load_en;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    bit          is_err;
    logic [4:0]  scode;
    logic [23:0] load;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   saw_not_ready;

  bus_dest_sequencer #(.DEPTH(2)) dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .Scode     (Scode),
    .load_en   (load_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic bit tb_legal(input logic [4:0] s, input logic [4:0] d);
    return (s < 5'd24) && ((d <= 5'd17) || (d == 5'd20) || (d == 5'd21));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (clear) begin
      if (done) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done load_en=%06h Scode=%0d", load_en, Scode);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_err || load_en !== e.load || Scode !== e.scode) begin
            miscompares++;
            $display("FAIL sb_load got load_en=%06h Scode=%0d exp is_err=%0d load_en=%06h Scode=%0d",
                     load_en, Scode, e.is_err, e.load, e.scode);
          end
        end
      end else begin
        vectors++;
        if (load_en !== 24'h0) begin
          miscompares++;
          $display("FAIL load_without_done load_en=%06h exp=000000", load_en);
        end
      end
      if (err) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_err err=1 exp queue empty");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!e.is_err) begin
            miscompares++;
            $display("FAIL sb_err got err=1 exp load_en=%06h Scode=%0d", e.load, e.scode);
          end
        end
      end
    end
  end

  task automatic push(input logic [4:0] s, input logic [4:0] d);
    bit   accepted;
    int   n;
    exp_t e;
    accepted  = 0;
    n         = 0;
    req_src   = s;
    req_dst   = d;
    req_valid = 1'b1;
    while (!accepted && n < 40) begin
      if (req_ready) begin
        accepted = 1;
        e.is_err = !tb_legal(s, d);
        e.scode  = s;
        e.load   = e.is_err ? 24'h0 : (24'h1 << d);
        exp_q.push_back(e);
      end else begin
        saw_not_ready = 1;
      end
      tick();
      n++;
    end
    req_valid = 1'b0;
    if (!accepted) begin
      miscompares++;
      $display("FAIL push_timeout req %0d->%0d never accepted", s, d);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!busy && exp_q.size() == 0) break;
      tick();
    end
    vectors++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain busy=%0b pending=%0d exp busy=0 pending=0", name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    for (int ph = 0; ph < 2; ph++) begin
      vectors++;
      if (Scode !== 5'd0 || load_en !== 24'h0 || done !== 1'b0 || err !== 1'b0 ||
          busy !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_ph%0d Scode=%0d load_en=%06h done=%0b err=%0b busy=%0b ready=%0b exp 0/0/0/0/0/1",
                 ph, Scode, load_en, done, err, busy, req_ready);
      end
      clear = 1'b1;
      tick();
    end
  endtask

  task automatic test_single();
    push(5'd20, 5'd21);
    tick();
    vectors++;
    if (Scode !== 5'd20 || load_en !== 24'h0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_drive Scode=%0d load_en=%06h busy=%0b exp 20/000000/1", Scode, load_en, busy);
    end
    tick();
    vectors++;
    if (load_en !== 24'h20_0000 || done !== 1'b1 || Scode !== 5'd20) begin
      miscompares++;
      $display("FAIL single_load load_en=%06h done=%0b Scode=%0d exp 200000/1/20", load_en, done, Scode);
    end
    tick();
    vectors++;
    if (load_en !== 24'h0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after load_en=%06h done=%0b exp 000000/0", load_en, done);
    end
    wait_idle("single");
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_load [3];
    logic [4:0]  exp_sc   [3];
    exp_load[0] = 24'h000020; exp_sc[0] = 5'd3;
    exp_load[1] = 24'h000080; exp_sc[1] = 5'd16;
    exp_load[2] = 24'h000001; exp_sc[2] = 5'd21;
    push(5'd3, 5'd5);
    push(5'd16, 5'd7);
    push(5'd21, 5'd0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (load_en !== exp_load[k] || Scode !== exp_sc[k] || done !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_load%0d load_en=%06h Scode=%0d done=%0b exp %06h/%0d/1",
                 k, load_en, Scode, done, exp_load[k], exp_sc[k]);
      end
      tick();
      if (k < 2) begin
        vectors++;
        if (Scode !== exp_sc[k+1] || load_en !== 24'h0) begin
          miscompares++;
          $display("FAIL b2b_drive%0d Scode=%0d load_en=%06h exp %0d/000000",
                   k + 1, Scode, load_en, exp_sc[k+1]);
        end
        tick();
      end
    end
    wait_idle("b2b");
  endtask

  task automatic test_illegal();
    push(5'd2, 5'd18);
    push(5'd4, 5'd22);
    push(5'd25, 5'd1);
    push(5'd1, 5'd2);
    vectors++;
    if (Scode !== 5'd21) begin
      miscompares++;
      $display("FAIL illegal_scode_hold Scode=%0d exp 21", Scode);
    end
    wait_idle("illegal");
  endtask

  task automatic test_full();
    saw_not_ready = 0;
    push(5'd0, 5'd1);
    push(5'd5, 5'd6);
    push(5'd16, 5'd17);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready req_ready=%0b exp 0", req_ready);
    end
    push(5'd20, 5'd10);
    vectors++;
    if (saw_not_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_stall saw_not_ready=%0b exp 1", saw_not_ready);
    end
    wait_idle("full");
  endtask

  task automatic test_reset_mid_load();
    push(5'd6, 5'd8);
    push(5'd7, 5'd9);
    push(5'd8, 5'd10);
    vectors++;
    if (done !== 1'b1 || load_en !== 24'h000100) begin
      miscompares++;
      $display("FAIL midreset_pre done=%0b load_en=%06h exp 1/000100", done, load_en);
    end
    #2;
    clear = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if (load_en !== 24'h0 || Scode !== 5'd0 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_abort load_en=%06h Scode=%0d done=%0b busy=%0b exp 000000/0/0/0",
               load_en, Scode, done, busy);
    end
    @(negedge clock);
    #2;
    clear = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || load_en !== 24'h0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_quiet%0d busy=%0b load_en=%06h err=%0b exp 0/000000/0",
                 i, busy, load_en, err);
      end
    end
  endtask

  task automatic test_self();
    push(5'd9, 5'd9);
    tick();
    vectors++;
    if (Scode !== 5'd9) begin
      miscompares++;
      $display("FAIL self_drive Scode=%0d exp 9", Scode);
    end
    tick();
    vectors++;
    if (load_en !== 24'h000200 || done !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL self_load load_en=%06h done=%0b err=%0b exp 000200/1/0", load_en, done, err);
    end
    wait_idle("self");
  endtask

  initial begin
    clear     = 1'b0;
    req_valid = 1'b0;
    req_src   = 5'd0;
    req_dst   = 5'd0;
    saw_not_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_full();
    test_reset_mid_load();
    test_self();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
